decode_stage: RTL
=================

Name: decode_stage

Overview:
- IF/ID pipeline stage sitting directly upstream of the immediate sign-extender.
- Accepts fetched instruction/PC pairs over a valid/ready handshake and buffers them in a 2-entry skid register.
- Decodes the 7-bit opcode into the 2-bit immediate-format select consumed by the sign-extender (00 I, 01 S, 10 B, 11 J) plus basic control flags.
- Presents instruction bits [31:7] and controls to the execute side.

Parameters:
- XLEN, 32, width of instruction and PC buses.
- RESET_PC, 32'h0000_0000, value driven on out_pc while no instruction is held.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush (branch/jump redirect).
- in_valid  input  1  fetch presents instruction.
- in_ready  output  1  stage can accept instruction.
- in_instr  input  XLEN  raw instruction word.
- in_pc  input  XLEN  PC of in_instr.
- out_valid  output  1  decoded instruction available.
- out_ready  input  1  downstream accepts.
- out_instr  output  25  instruction bits [31:7], feeds sign-extender input.
- out_imm_src  output  2  immediate format select, feeds sign-extender.
- out_pc  output  XLEN  PC of held instruction.
- out_uses_imm  output  1  ALU B operand is immediate.
- out_reg_write  output  1  writes rd.
- out_mem_write  output  1  store.
- out_branch  output  1  conditional branch.
- out_jump  output  1  JAL/JALR.

Behaviour:
- Reset (rst_n low, asynchronous): both entries invalid; out_valid=0; in_ready=1 once released; out_instr=0; out_imm_src=00; out_pc=RESET_PC; all flags 0.
- Storage: main register (drives outputs) plus one skid entry.
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- in_ready is registered: in_ready = !skid_valid. No combinational path from out_ready to in_ready.
- Latency: one cycle. An instruction accepted in cycle N is visible on outputs in cycle N+1 if the main register is empty or draining.
- Input accepted while main register full and not draining: goes to skid. Skid moves to main on the next output transfer.
- Simultaneous input and output transfer with skid empty: new instruction loads main directly.
- Ordering is strictly FIFO. No instruction is dropped or duplicated except by flush.
- Decode is registered with the instruction (opcode = in_instr[6:0]):
  - 0000011 load: src 00, uses_imm, reg_write.
  - 0010011 ALU-imm: src 00, uses_imm, reg_write.
  - 1100111 JALR: src 00, uses_imm, reg_write, jump.
  - 0100011 store: src 01, uses_imm, mem_write.
  - 1100011 branch: src 10, branch.
  - 1101111 JAL: src 11, reg_write, jump.
  - 0110011 R-type: src 00, reg_write only.
  - Any other opcode (including LUI/AUIPC): src 00, all flags 0.
- Flush:
  - Clears main and skid valid bits at the edge.
  - An instruction presented in the same cycle is discarded.
  - in_ready=1 the following cycle.
  - flush overrides simultaneous output transfer; the downstream transfer in that cycle still counts as taken.
- Output data is stable while out_valid && !out_ready.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output port out_illegal (1 bit, reset 0).
  - Asserted with the held instruction when the opcode is not in the decode list, or when in_instr[1:0] != 2'b11.
  - All other flags for that instruction remain 0.
- Undefined: port absent; unlisted opcodes decode silently as a NOP-like entry.

Test Plan:
- Reset then in 0x00500093 @pc 0x100, out_ready=1 -> next cycle out_valid=1, out_instr=0x00A001, out_imm_src=00, uses_imm=1, reg_write=1, out_pc=0x100.
- Back-to-back 0x0020A423, 0x00208863, 0x008000EF with out_ready=1 -> consecutive outputs:
  - imm_src 01 with mem_write.
  - imm_src 10 with branch.
  - imm_src 11 with jump and reg_write.
- out_ready=0, push 3 instructions -> in_ready drops after 2 accepted. Release out_ready -> all 2 emitted in order, then the third is accepted.
- Main and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, the presented word is lost.
- rst_n low mid-stall with 2 entries held -> outputs return to reset values immediately, without a clock edge.
- With DECODE_ILLEGAL_TRAP_EN, in 0x00000037 (LUI) -> out_illegal=1, all other flags 0. Without the macro -> flags 0, no port.

Source files
------------

// File: rtl/decode_stage.sv
// IF/ID decode stage: 2-entry skid buffer feeding the immediate sign-extender.
// Optional out_illegal flag is enabled with `define DECODE_ILLEGAL_TRAP_EN.
module decode_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [24:0]     out_instr,
    output logic [1:0]      out_imm_src,
    output logic [XLEN-1:0] out_pc,
    output logic            out_uses_imm,
    output logic            out_reg_write,
    output logic            out_mem_write,
    output logic            out_branch,
    output logic            out_jump
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic            out_illegal
`endif
);

    typedef struct packed {
        logic [24:0]     instr;
        logic [1:0]      imm_src;
        logic [XLEN-1:0] pc;
        logic            uses_imm;
        logic            reg_write;
        logic            mem_write;
        logic            branch;
        logic            jump;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic            illegal;
`endif
    } entry_t;

    function automatic entry_t decode(input logic [XLEN-1:0] instr, input logic [XLEN-1:0] pc);
        entry_t e;
        e       = '0;
        e.instr = instr[31:7];
        e.pc    = pc;
        case (instr[6:0])
            7'b0000011, 7'b0010011: begin
                e.uses_imm  = 1'b1;
                e.reg_write = 1'b1;
            end
            7'b1100111: begin
                e.uses_imm  = 1'b1;
                e.reg_write = 1'b1;
                e.jump      = 1'b1;
            end
            7'b0100011: begin
                e.imm_src   = 2'b01;
                e.uses_imm  = 1'b1;
                e.mem_write = 1'b1;
            end
            7'b1100011: begin
                e.imm_src = 2'b10;
                e.branch  = 1'b1;
            end
            7'b1101111: begin
                e.imm_src   = 2'b11;
                e.reg_write = 1'b1;
                e.jump      = 1'b1;
            end
            7'b0110011: e.reg_write = 1'b1;
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                e.illegal = 1'b1;
`endif
            end
        endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
        // Compressed/invalid length encodings trap with every other flag cleared.
        if (instr[1:0] != 2'b11) begin
            e.imm_src   = 2'b00;
            e.uses_imm  = 1'b0;
            e.reg_write = 1'b0;
            e.mem_write = 1'b0;
            e.branch    = 1'b0;
            e.jump      = 1'b0;
            e.illegal   = 1'b1;
        end
`endif
        return e;
    endfunction

    entry_t main_q, skid_q, in_entry;
    logic   main_valid, skid_valid;
    logic   in_fire, out_fire, main_free;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and in_ready depends only on registered skid state.
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign in_fire   = in_valid && in_ready && !flush;
    assign out_fire  = main_valid && out_ready;
    assign main_free = out_fire || !main_valid;
    assign in_entry  = decode(in_instr, in_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            // Skid holds the older word, so it always wins the main slot.
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                main_q     <= in_entry;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q     <= in_entry;
            skid_valid <= 1'b1;
        end
    end

    assign out_instr     = main_valid ? main_q.instr   : '0;
    assign out_imm_src   = main_valid ? main_q.imm_src : 2'b00;
    assign out_pc        = main_valid ? main_q.pc      : RESET_PC;
    assign out_uses_imm  = main_valid && main_q.uses_imm;
    assign out_reg_write = main_valid && main_q.reg_write;
    assign out_mem_write = main_valid && main_q.mem_write;
    assign out_branch    = main_valid && main_q.branch;
    assign out_jump      = main_valid && main_q.jump;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign out_illegal   = main_valid && main_q.illegal;
`endif

endmodule
